// File: rtl/icache_pkg.sv
// Shared types and width constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned AddrBits         = 32;
  localparam int unsigned IndexBitsDefault = 6;
  localparam int unsigned TagBitsDefault   = AddrBits - IndexBitsDefault - 2;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  // Tag width for a given number of index bits (one 32-bit word per line).
  function automatic int unsigned tag_bits(int unsigned index_bits);
    return AddrBits - index_bits - 2;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side handshake and byte-wide memory port of the instruction cache.
interface icache_if;
  import icache_pkg::*;

  logic                if_req;
  logic [AddrBits-1:0] if_addr;
  logic                flush;
  logic                if_ready;
  logic                if_ok;
  logic [31:0]         if_inst;
  logic                if_hit;

  logic                mem_busy;
  logic [7:0]          mem_din;
  logic [AddrBits-1:0] mem_a;
  logic                mem_rd_en;

  // Requester and memory side.
  modport master (
    output if_req, if_addr, flush, mem_busy, mem_din,
    input  if_ready, if_ok, if_inst, if_hit, mem_a, mem_rd_en
  );

  // Cache side.
  modport slave (
    input  if_req, if_addr, flush, mem_busy, mem_din,
    output if_ready, if_ok, if_inst, if_hit, mem_a, mem_rd_en
  );

endinterface

// File: rtl/icache_fill.sv
// Line fill engine: issues four byte reads and assembles them little-endian into one word.
module icache_fill
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic                mem_busy,
  input  logic [7:0]          mem_din,
  input  logic [AddrBits-3:0] base,
  output logic                mem_rd_en,
  output logic [AddrBits-1:0] mem_a,
  output logic                done,
  output logic [31:0]         word
);

  logic [2:0]      issue_q, issue_d;
  logic [2:0]      cap_q, cap_d;
  logic            pend_q, pend_d;
  logic [1:0]      pend_lane_q, pend_lane_d;
  logic [3:0][7:0] lanes_q, lanes_d;

  always_comb begin
    issue_d     = issue_q;
    cap_d       = cap_q;
    pend_d      = 1'b0;
    pend_lane_d = pend_lane_q;
    lanes_d     = lanes_q;
    mem_rd_en   = 1'b0;
    mem_a       = '0;
    done        = 1'b0;
    if (!active) begin
      // Any exit from the fill (finish, flush, reset) discards partial state.
      issue_d     = '0;
      cap_d       = '0;
      pend_lane_d = '0;
      lanes_d     = '0;
    end else begin
      if (!mem_busy && (issue_q < 3'd4)) begin
        mem_rd_en   = 1'b1;
        mem_a       = {base, issue_q[1:0]};
        issue_d     = issue_q + 3'd1;
        pend_d      = 1'b1;
        pend_lane_d = issue_q[1:0];
      end
      // The byte issued last cycle lands now, whether or not the port is busy.
      if (pend_q) begin
        lanes_d[pend_lane_q] = mem_din;
        cap_d                = cap_q + 3'd1;
        done                 = (cap_q == 3'd3);
      end
    end
    word = lanes_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q     <= '0;
      cap_q       <= '0;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      lanes_q     <= '0;
    end else begin
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      lanes_q     <= lanes_d;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line, filled bytewise from a shared memory port.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = IndexBitsDefault,
  parameter int unsigned BYTE_LAT   = 1
) (
  input logic   clk,
  input logic   rst,
  icache_if.slave bus
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = tag_bits(INDEX_BITS);

  if (BYTE_LAT != 1) begin : g_lat_check
    $error("icache: only BYTE_LAT=1 is supported");
  end

  state_e              state_q, state_d;
  logic [AddrBits-3:0] addr_q, addr_d;
  logic [31:0]         inst_q, inst_d;
  logic                hit_q, hit_d;

  logic [Lines-1:0]    valid_q;
  logic [TagBits-1:0]  tag_mem  [Lines];
  logic [31:0]         data_mem [Lines];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TagBits-1:0]    req_tag, fill_tag;
  logic                  lookup_hit, accept, fill_active, fill_done;
  logic [31:0]           fill_word;
  logic                  unused_addr_bits;

  assign req_idx          = bus.if_addr[INDEX_BITS+1:2];
  assign req_tag          = bus.if_addr[AddrBits-1:INDEX_BITS+2];
  assign fill_idx         = addr_q[INDEX_BITS-1:0];
  assign fill_tag         = addr_q[AddrBits-3:INDEX_BITS];
  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign lookup_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept      = (state_q == StIdle) && bus.if_req && !bus.flush && !rst;
  assign fill_active = (state_q == StFill) && !bus.flush && !rst;

  icache_fill u_fill (
    .clk       (clk),
    .rst       (rst),
    .active    (fill_active),
    .mem_busy  (bus.mem_busy),
    .mem_din   (bus.mem_din),
    .base      (addr_q),
    .mem_rd_en (bus.mem_rd_en),
    .mem_a     (bus.mem_a),
    .done      (fill_done),
    .word      (fill_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    hit_d   = hit_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = bus.if_addr[AddrBits-1:2];
          if (lookup_hit) begin
            state_d = StDone;
            inst_d  = data_mem[req_idx];
            hit_d   = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (fill_done) begin
          state_d = StDone;
          inst_d  = fill_word;
          hit_d   = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      inst_q  <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      hit_q   <= hit_d;
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_word;
    end
  end

  assign bus.if_ready = (state_q == StIdle) && !bus.flush && !rst;
  assign bus.if_ok    = (state_q == StDone) && !bus.flush && !rst;
  assign bus.if_inst  = rst ? '0 : inst_q;
  assign bus.if_hit   = rst ? 1'b0 : hit_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: byte memory model, expected fetch results queued at request time.
module tb_icache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic        hit;
    int unsigned cyc;
    bit          timed;
  } exp_t;

  exp_t sb[$];

  icache_if bus ();

  icache #(
    .INDEX_BITS (6),
    .BYTE_LAT   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h10:  return 8'h13;
      32'h11:  return 8'h05;
      32'h12:  return 8'h10;
      32'h13:  return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [31:0] b;
    b = {addr[31:2], 2'b00};
    return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
  endfunction

  // Memory answers one cycle after each issue.
  always @(posedge clk) bus.mem_din <= bus.mem_rd_en ? mem_byte(bus.mem_a) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_ok === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("inst", bus.if_inst, e.inst);
        check("hit", {31'd0, bus.if_hit}, {31'd0, e.hit});
        if (e.timed) check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request; returns one cycle later with if_req dropped.
  task automatic fetch(input logic [31:0] addr, input logic exp_hit, input int unsigned lat,
                       input bit expect_ok);
    int unsigned guard = 0;
    while (bus.if_ready !== 1'b1 && guard < 50) begin
      next_cycle();
      guard++;
    end
    check("ready_before_req", {31'd0, bus.if_ready}, 32'd1);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    if (expect_ok) sb.push_back('{exp_word(addr), exp_hit, cyc + lat, lat != 0});
    next_cycle();
    bus.if_req = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      next_cycle();
      guard++;
    end
    check("drain", sb.size(), 32'd0);
    next_cycle();
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.flush    = 1'b0;
    bus.mem_busy = 1'b0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_ready", {31'd0, bus.if_ready}, 32'd0);
    check("rst_ok", {31'd0, bus.if_ok}, 32'd0);
    check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_inst", bus.if_inst, 32'd0);
    check("rst_hit", {31'd0, bus.if_hit}, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Cold miss: four byte issues, then the word
    fetch(32'h10, 1'b0, 6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cold_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      check("cold_mem_a", bus.mem_a, 32'h10 + i);
      next_cycle();
    end
    drain();
    check("cold_inst_value", bus.if_inst, 32'h00100513);

    // Hit: no memory traffic
    fetch(32'h10, 1'b1, 1, 1'b1);
    @(negedge clk);
    check("hit_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    drain();

    // Conflict on the same index evicts the line
    fetch(32'h110, 1'b0, 6, 1'b1);
    drain();
    fetch(32'h10, 1'b0, 6, 1'b1);
    drain();

    // Busy for three cycles after the second issue
    fetch(32'h40, 1'b0, 9, 1'b1);
    next_cycle();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
      next_cycle();
    end
    bus.mem_busy = 1'b0;
    drain();

    // Flush in the third fill cycle
    fetch(32'h80, 1'b0, 0, 1'b0);
    next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_ready", {31'd0, bus.if_ready}, 32'd0);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("flush_idle", {31'd0, bus.if_ready}, 32'd1);
    for (int i = 0; i < 8; i++) next_cycle();
    fetch(32'h80, 1'b0, 6, 1'b1);
    drain();

    // Flush and request together: request dropped
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.flush   = 1'b1;
    next_cycle();
    bus.if_req = 1'b0;
    bus.flush  = 1'b0;
    @(negedge clk);
    check("flushreq_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("flushreq_ready", {31'd0, bus.if_ready}, 32'd1);
    next_cycle();

    // Reset in the second fill cycle
    fetch(32'hC0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("midrst_mem_a", bus.mem_a, 32'd0);
    check("midrst_ready", {31'd0, bus.if_ready}, 32'd0);
    check("midrst_inst", bus.if_inst, 32'd0);
    check("midrst_hit", {31'd0, bus.if_hit}, 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
    fetch(32'hC0, 1'b0, 6, 1'b1);
    drain();
    fetch(32'h10, 1'b0, 6, 1'b1);
    drain();

    // Back-to-back same address: second lookup sees the fresh line
    fetch(32'h200, 1'b0, 6, 1'b1);
    fetch(32'h200, 1'b1, 1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of line count (one 32-bit word per line).
REQ-002 SHALL have parameter BYTE_LAT, default 1, meaning memory read latency in cycles (only 1 supported).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_req  input  1  fetch request, accepted only when if_ready=1.
REQ-006 SHALL have port if_addr  input  32  fetch address; bits [1:0] ignored.
REQ-007 SHALL have port flush  input  1  abort request from execute on redirect.
REQ-008 SHALL have port mem_busy  input  1  memory port granted to data side; no new byte issue.
REQ-009 SHALL have port mem_din  input  8  byte read data, valid one cycle after issue.
REQ-010 SHALL have port if_ready  output  1  high when idle and flush=0.
REQ-011 SHALL have port if_ok  output  1  one-cycle pulse, if_inst valid.
REQ-012 SHALL have port if_inst  output  32  fetched instruction, little-endian.
REQ-013 SHALL have port if_hit  output  1  qualifies if_ok: 1 = served from cache, 0 = from fill.
REQ-014 SHALL have port mem_a  output  32  byte address to memory.
REQ-015 SHALL have port mem_rd_en  output  1  byte read issue strobe.

Function
REQ-016 SHALL split aligned address: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; per line store valid, tag, data.
REQ-017 SHALL implement states IDLE, FILL, DONE.
REQ-018 IDLE: on if_req=1 and flush=0 capture address; hit (valid and tag match) -> DONE with if_hit=1; miss -> FILL with issue counter 0.
REQ-019 FILL: each cycle with mem_busy=0 and issue count <4, drive mem_a=base+count, mem_rd_en=1, increment count; mem_busy=1 holds count, mem_rd_en=0.
REQ-020 FILL: byte returned one cycle after its issue SHALL be captured into byte lane = its offset, regardless of mem_busy.
REQ-021 FILL: after fourth byte captured, write line (valid=1, tag, data) and go DONE with if_hit=0.
REQ-022 DONE: if_ok=1 for exactly one cycle with if_inst and if_hit; then IDLE.
REQ-023 Latency: hit request in cycle N -> if_ok in cycle N+1; miss with mem_busy=0 -> issues in N+1..N+4, bytes in N+2..N+5, if_ok in N+6.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, suppress if_ok, discard partial fill, leave line array unwritten.
REQ-025 flush and if_req in same cycle: flush wins, request dropped.
REQ-026 if_req while if_ready=0 SHALL be ignored.
REQ-027 Fill SHALL complete line write before a following request's lookup (back-to-back same address hits).
REQ-028 Outputs when idle: if_ok=0, mem_rd_en=0, mem_a=0; if_inst holds last value.

Reset
REQ-029 rst=1 SHALL clear all valid bits, state=IDLE, count=0, if_ok=0, if_hit=0, if_inst=0, mem_rd_en=0, mem_a=0, if_ready=0 during reset.
REQ-030 rst mid-fill SHALL abandon fill without line write; late byte ignored.

Structure
REQ-031 Shared package SHALL hold the state enumeration, INDEX_BITS default and tag/index width constants.
REQ-032 Sub-module icache_fill (byte issue counter plus lane assembler) SHALL be separate; array and FSM in icache.

Verification
REQ-033 Cold miss: rst then if_req addr 0x00000010, memory bytes 0x13,0x05,0x10,0x00 -> mem_a 0x10..0x13 in cycles 1..4, if_ok cycle 6, if_inst=0x00100513, if_hit=0.
REQ-034 Hit: repeat request 0x00000010 -> if_ok next cycle, if_inst=0x00100513, if_hit=1, mem_rd_en stays 0.
REQ-035 Conflict: request 0x00000110 (same index, other tag) -> miss, fill; then 0x00000010 -> miss again.
REQ-036 Busy: mem_busy=1 for 3 cycles after second byte issue -> if_ok delayed 3 cycles, if_inst correct.
REQ-037 Flush: flush in cycle 3 of fill -> no if_ok, mem_rd_en 0 next cycle, later request to same address misses.
REQ-038 Reset mid-fill: rst in cycle 2 -> outputs zero, subsequent request to same address misses.
